ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 143 ++++++++++++++
 tb/tb_ram_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-master single-port RAM arbiter: round-robin between fetch (m0) and load/store (m1),
// with an m1 exclusive lock that is force-released after LOCK_MAX cycles.
module ram_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MW       = 4,
    parameter int LOCK_MAX = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_wdata_i,
    input  logic [MW-1:0] m0_sel_i,
    output logic          m0_gnt_o,
    output logic          m0_rvalid_o,
    output logic [DW-1:0] m0_rdata_o,
    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_wdata_i,
    input  logic [MW-1:0] m1_sel_i,
    input  logic          m1_lock_i,
    output logic          m1_gnt_o,
    output logic          m1_rvalid_o,
    output logic [DW-1:0] m1_rdata_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_wdata_o,
    output logic [MW-1:0] ram_sel_o,
    output logic          ram_we_o,
    input  logic [DW-1:0] ram_rdata_i,
    output logic          lock_err_o
);
    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);

    typedef enum logic {ARB, LOCK} state_t;

    state_t        state, state_nx;
    logic          last_gnt, last_gnt_nx;   // 1: m1 was granted most recently
    logic [CW-1:0] cnt, cnt_nx;
    logic          inhibit, inhibit_nx;
    logic          rst_q;
    logic          rsp_vld, rsp_owner, rsp_we;

    always_comb begin
        m0_gnt_o    = 1'b0;
        m1_gnt_o    = 1'b0;
        lock_err_o  = 1'b0;
        state_nx    = state;
        cnt_nx      = cnt;
        last_gnt_nx = last_gnt;
        inhibit_nx  = inhibit;
        // grants are held off during reset and the cycle right after it
        if (!(rst || rst_q)) begin
            if (state == LOCK) begin
                m1_gnt_o = m1_req_i;
            end else if (m0_req_i && m1_req_i) begin
                m0_gnt_o = last_gnt;
                m1_gnt_o = !last_gnt;
            end else begin
                m0_gnt_o = m0_req_i;
                m1_gnt_o = m1_req_i;
            end
        end
        if (m0_gnt_o) last_gnt_nx = 1'b0;
        if (m1_gnt_o) last_gnt_nx = 1'b1;
        case (state)
            ARB: begin
                cnt_nx = '0;
                if (m1_gnt_o && m1_lock_i && !inhibit) begin
                    state_nx = LOCK;
                    cnt_nx   = CW'(1);
                end
                if (!m1_lock_i) inhibit_nx = 1'b0;
            end
            LOCK: begin
                if (!m1_lock_i) begin
                    state_nx    = ARB;
                    cnt_nx      = '0;
                    last_gnt_nx = 1'b1;
                end else if (cnt == CNT_MAX) begin
                    state_nx    = ARB;
                    cnt_nx      = '0;
                    last_gnt_nx = 1'b1;
                    inhibit_nx  = 1'b1;
                    lock_err_o  = !rst;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = ARB;
        endcase
    end

    always_comb begin
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_sel_o   = '0;
        ram_we_o    = 1'b0;
        if (m0_gnt_o) begin
            ram_addr_o  = m0_addr_i;
            ram_wdata_o = m0_wdata_i;
            ram_sel_o   = m0_sel_i;
            ram_we_o    = m0_we_i;
        end else if (m1_gnt_o) begin
            ram_addr_o  = m1_addr_i;
            ram_wdata_o = m1_wdata_i;
            ram_sel_o   = m1_sel_i;
            ram_we_o    = m1_we_i;
        end
    end

    always_ff @(posedge clk) rst_q <= rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB;
            last_gnt  <= 1'b1;
            cnt       <= '0;
            inhibit   <= 1'b0;
            rsp_vld   <= 1'b0;
            rsp_owner <= 1'b0;
            rsp_we    <= 1'b0;
        end else begin
            state     <= state_nx;
            last_gnt  <= last_gnt_nx;
            cnt       <= cnt_nx;
            inhibit   <= inhibit_nx;
            rsp_vld   <= m0_gnt_o || m1_gnt_o;
            rsp_owner <= m1_gnt_o;
            rsp_we    <= ram_we_o;
        end
    end

    // an in-flight response is dropped as soon as reset is seen
    assign m0_rvalid_o = rsp_vld && !rsp_owner && !rst;
    assign m1_rvalid_o = rsp_vld &&  rsp_owner && !rst;
    assign m0_rdata_o  = (m0_rvalid_o && !rsp_we) ? ram_rdata_i : '0;
    assign m1_rdata_o  = (m1_rvalid_o && !rsp_we) ? ram_rdata_i : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized + directed bench for ram_arbiter against a transaction-level reference model
// with its own shadow memory; a simple behavioural RAM sits on the DUT's RAM port.
module tb_ram_arbiter;
    localparam int LM = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i, m1_lock_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, ram_we_o, lock_err_o;
    logic [31:0] m0_rdata_o, m1_rdata_o, ram_addr_o, ram_wdata_o, ram_rdata_i;
    logic [3:0]  ram_sel_o;

    ram_arbiter #(.AW(32), .DW(32), .MW(4), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
        .m0_wdata_i(m0_wdata_i), .m0_sel_i(m0_sel_i), .m0_gnt_o(m0_gnt_o),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
        .m1_wdata_i(m1_wdata_i), .m1_sel_i(m1_sel_i), .m1_lock_i(m1_lock_i),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_sel_o(ram_sel_o),
        .ram_we_o(ram_we_o), .ram_rdata_i(ram_rdata_i), .lock_err_o(lock_err_o)
    );

    always #5 clk = ~clk;

    // behavioural RAM: registered address, combinational array read, byte-select write
    logic [31:0] mem [256];
    logic [7:0]  addr_q = 8'd0;
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_we_o && ram_sel_o[b]) mem[ram_addr_o[7:0]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
        addr_q <= ram_addr_o[7:0];
    end
    assign ram_rdata_i = mem[addr_q];

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // stimulus to apply in the next cycle
    logic        r0, w0, r1, w1, lk, rs;
    logic [31:0] a0, d0, a1, d1;
    logic [3:0]  s0, s1;

    // reference model: ownership and priority as rules, memory as a plain array
    logic [31:0] shadow [256];
    bit          locked, inhibit, prefer_m0, after_rst;
    int          lock_cycles;
    bit          pend, pend_m1, pend_wr;
    logic [7:0]  pend_addr;

    // observations of the latest cycle, used by directed checks
    logic [31:0] last_rd0, last_rd1;
    int          g0_seen, err_seen;

    task automatic step();
        bit e_g0, e_g1, e_err, e_rv0, e_rv1, e_we;
        logic [31:0] e_rd0, e_rd1, e_addr, e_wd;
        logic [3:0]  e_sel;
        @(negedge clk);
        rst = rs;
        m0_req_i = r0; m0_we_i = w0; m0_addr_i = a0; m0_wdata_i = d0; m0_sel_i = s0;
        m1_req_i = r1; m1_we_i = w1; m1_addr_i = a1; m1_wdata_i = d1; m1_sel_i = s1;
        m1_lock_i = lk;
        #1;
        e_g0 = 0; e_g1 = 0;
        if (!(rs || after_rst)) begin
            if (locked)        e_g1 = r1;
            else if (r0 && r1) begin e_g0 = prefer_m0; e_g1 = !prefer_m0; end
            else               begin e_g0 = r0; e_g1 = r1; end
        end
        e_err  = locked && lk && lock_cycles == LM && !rs;
        e_rv0  = pend && !pend_m1 && !rs;
        e_rv1  = pend &&  pend_m1 && !rs;
        e_rd0  = (e_rv0 && !pend_wr) ? shadow[pend_addr] : 32'd0;
        e_rd1  = (e_rv1 && !pend_wr) ? shadow[pend_addr] : 32'd0;
        e_we   = e_g0 ? w0 : e_g1 ? w1 : 1'b0;
        e_addr = e_g0 ? a0 : e_g1 ? a1 : 32'd0;
        e_wd   = e_g0 ? d0 : e_g1 ? d1 : 32'd0;
        e_sel  = e_g0 ? s0 : e_g1 ? s1 : 4'd0;
        chk("m0_gnt", m0_gnt_o, e_g0);
        chk("m1_gnt", m1_gnt_o, e_g1);
        chk("m0_rvalid", m0_rvalid_o, e_rv0);
        chk("m1_rvalid", m1_rvalid_o, e_rv1);
        chk("m0_rdata", m0_rdata_o, e_rd0);
        chk("m1_rdata", m1_rdata_o, e_rd1);
        chk("ram_we", ram_we_o, e_we);
        chk("ram_addr", ram_addr_o, e_addr);
        chk("ram_wdata", ram_wdata_o, e_wd);
        chk("ram_sel", ram_sel_o, e_sel);
        chk("lock_err", lock_err_o, e_err);
        last_rd0 = m0_rdata_o; last_rd1 = m1_rdata_o;
        g0_seen += int'(m0_gnt_o); err_seen += int'(lock_err_o);
        @(posedge clk);
        if (rs) begin
            locked = 0; inhibit = 0; prefer_m0 = 1; lock_cycles = 0; pend = 0; after_rst = 1;
        end else begin
            after_rst = 0;
            pend = e_g0 || e_g1; pend_m1 = e_g1; pend_wr = e_we; pend_addr = e_addr[7:0];
            for (int b = 0; b < 4; b++)
                if (e_we && e_sel[b]) shadow[e_addr[7:0]][8*b +: 8] = e_wd[8*b +: 8];
            if (e_g0) prefer_m0 = 0;
            if (e_g1) prefer_m0 = 1;
            if (locked) begin
                if (!lk) begin
                    locked = 0; lock_cycles = 0; prefer_m0 = 1;
                end else if (lock_cycles == LM) begin
                    locked = 0; lock_cycles = 0; prefer_m0 = 1; inhibit = 1;
                end else lock_cycles++;
            end else begin
                if (e_g1 && lk && !inhibit) begin locked = 1; lock_cycles = 1; end
                if (!lk) inhibit = 0;
            end
        end
    endtask

    task automatic idle();
        r0 = 0; w0 = 0; a0 = 0; d0 = 0; s0 = 0;
        r1 = 0; w1 = 0; a1 = 0; d1 = 0; s1 = 0; lk = 0;
    endtask

    task automatic rd0(input logic [31:0] a); r0 = 1; w0 = 0; a0 = a; d0 = 0; s0 = 4'hF; endtask
    task automatic rd1(input logic [31:0] a); r1 = 1; w1 = 0; a1 = a; d1 = 0; s1 = 4'hF; endtask
    task automatic wr1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        r1 = 1; w1 = 1; a1 = a; d1 = d; s1 = s;
    endtask

    int e0;

    initial begin
        for (int i = 0; i < 256; i++) begin mem[i] = i * 32'h01010101; shadow[i] = i * 32'h01010101; end
        locked = 0; inhibit = 0; prefer_m0 = 1; after_rst = 0; lock_cycles = 0;
        pend = 0; pend_m1 = 0; pend_wr = 0; pend_addr = 0; g0_seen = 0; err_seen = 0;
        idle(); rs = 1;
        repeat (3) step();
        rs = 0;

        // both masters read right after reset
        rd0(32'h10); rd1(32'h20); step(); step();
        r0 = 0; step();
        idle(); step();
        chk("rr_m1_data", last_rd1, 32'h20202020);

        // full-word write then immediate read of same address by m0
        wr1(32'd5, 32'hDEADBEEF, 4'b1111); step();
        idle(); rd0(32'd5); step();
        idle(); step();
        chk("raw_data", last_rd0, 32'hDEADBEEF);

        // byte-select partial write
        wr1(32'd7, 32'h11223344, 4'b1111); step();
        wr1(32'd7, 32'h0000AB00, 4'b0010); step();
        idle(); rd1(32'd7); step();
        idle(); step();
        chk("bytesel_data", last_rd1, 32'h1122AB44);

        // lock with m0 requesting continuously
        rd1(32'd1); lk = 1; step();
        e0 = g0_seen;
        rd0(32'd2); repeat (5) step();
        chk("lock_m0_blocked", 64'(g0_seen - e0), 64'd0);
        lk = 0; r1 = 0; step();
        e0 = g0_seen; step();
        chk("m0_after_lock", 64'(g0_seen - e0), 64'd1);
        idle(); step();

        // lock held past LOCK_MAX: forced release, no relock while lock stays high
        e0 = err_seen;
        rd1(32'd3); lk = 1; step();
        rd0(32'd4); repeat (LM + 3) step();
        chk("lock_err_once", 64'(err_seen - e0), 64'd1);
        lk = 0; step();
        idle(); step();

        // reset the cycle after a read grant
        rd0(32'd9); step();
        idle(); rs = 1; step();
        rs = 0; step();
        rd0(32'd10); rd1(32'd11); e0 = g0_seen; step();
        chk("m0_wins_after_rst", 64'(g0_seen - e0), 64'd1);
        idle(); step();

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            r0 = ($urandom_range(0, 3) != 0); w0 = $urandom_range(0, 1);
            a0 = $urandom_range(0, 15); d0 = $urandom; s0 = 4'($urandom);
            r1 = ($urandom_range(0, 3) != 0); w1 = $urandom_range(0, 1);
            a1 = $urandom_range(0, 15); d1 = $urandom; s1 = 4'($urandom);
            if (lk) lk = ($urandom_range(0, 9) != 0);
            else    lk = ($urandom_range(0, 5) == 0);
            rs = ($urandom_range(0, 299) == 0);
            step();
        end
        rs = 0; idle(); step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
